// File: rtl/ctrl_pipe.sv
// Pipelined control unit for the 16-bit WISC datapath: ID decode, ID/EX, EX/MEM
// and MEM/WB control registers, load-use stall and the HALT drain/dump sequence.
module ctrl_pipe #(
  parameter int REG_ADDR_W   = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int TRAP_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  input  logic                  flush,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [4:0]            ex_aluOp,
  output logic [1:0]            ex_aluF,
  output logic                  ex_aluSrc,
  output logic                  ex_zeroEx,
  output logic [1:0]            ex_size,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  mem_valid,
  output logic                  mem_memRead,
  output logic                  mem_memWrite,
  output logic                  wb_valid,
  output logic                  wb_regWrite,
  output logic                  wb_memToReg,
  output logic [REG_ADDR_W-1:0] wb_wreg,
  output logic [REG_ADDR_W-1:0] ex_wreg,
  output logic [REG_ADDR_W-1:0] mem_wreg,
  output logic                  illegal,
  output logic                  halted,
  output logic                  dump
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2, ST_STOP = 2'd3} state_t;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            alu_op;
    logic [1:0]            alu_f;
    logic                  alu_src;
    logic                  zero_ex;
    logic [1:0]            size;
    logic                  branch;
    logic                  jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] wreg;
  } ctrl_t;

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic                  illegal_r, dump_r, halted_r;
  ctrl_t                 ex_r;
  logic                  mem_valid_r, mem_rd_r, mem_wr_r, mem_rw_r, mem_m2r_r;
  logic [REG_ADDR_W-1:0] mem_wreg_r;
  logic                  wb_valid_r, wb_rw_r, wb_m2r_r;
  logic [REG_ADDR_W-1:0] wb_wreg_r;

  ctrl_t       dec_s;
  logic [1:0]  rdst_s;
  logic        is_halt_s, is_trap_s, uses_rt_s, hazard_s, id_live_s, accept_s;
  logic [4:0]  op_s;

  assign op_s = instr[15:11];

  // Opcode decode; HALT, NOP, RTI and (untrapped) SIIC all come out as bubbles.
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = 1'b1;
    dec_s.alu_op  = op_s;
    rdst_s        = 2'b00;
    is_halt_s     = 1'b0;
    is_trap_s     = 1'b0;
    uses_rt_s     = 1'b0;
    case (op_s)
      5'b00000: begin dec_s.valid = 1'b0; is_halt_s = 1'b1; end
      5'b00001, 5'b00011: dec_s.valid = 1'b0;
      5'b00010: begin dec_s.valid = 1'b0; is_trap_s = (TRAP_EN != 0); end
      5'b01000, 5'b01001, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1;
      end
      5'b01010, 5'b01011: begin
        dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.zero_ex = 1'b1;
      end
      5'b10000: begin dec_s.alu_src = 1'b1; dec_s.mem_write = 1'b1; uses_rt_s = 1'b1; end
      5'b10001: begin
        dec_s.alu_src = 1'b1; dec_s.mem_read = 1'b1; dec_s.reg_write = 1'b1; dec_s.mem_to_reg = 1'b1;
      end
      5'b10011: begin
        dec_s.alu_src = 1'b1; dec_s.mem_write = 1'b1; dec_s.reg_write = 1'b1;
        rdst_s = 2'b10; uses_rt_s = 1'b1;
      end
      5'b10010: begin
        dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.zero_ex = 1'b1;
        dec_s.size = 2'b01; rdst_s = 2'b10;
      end
      5'b11000: begin
        dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.size = 2'b01; rdst_s = 2'b10;
      end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
        dec_s.branch = 1'b1; dec_s.size = 2'b01; rdst_s = 2'b10;
      end
      5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
        dec_s.reg_write = 1'b1; rdst_s = 2'b01; uses_rt_s = 1'b1;
      end
      5'b11011: begin
        dec_s.reg_write = 1'b1; rdst_s = 2'b01; uses_rt_s = 1'b1;
        dec_s.alu_f = instr[1:0]; dec_s.zero_ex = (instr[1:0] == 2'b11);
      end
      5'b11010: begin
        dec_s.reg_write = 1'b1; rdst_s = 2'b01; uses_rt_s = 1'b1; dec_s.alu_f = instr[1:0];
      end
      5'b00100: begin dec_s.jump = 1'b1; dec_s.size = 2'b10; end
      5'b00101: begin dec_s.jump = 1'b1; dec_s.alu_src = 1'b1; dec_s.size = 2'b01; rdst_s = 2'b10; end
      5'b00110: begin dec_s.jump = 1'b1; dec_s.reg_write = 1'b1; dec_s.size = 2'b10; rdst_s = 2'b11; end
      5'b00111: begin
        dec_s.jump = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_src = 1'b1;
        dec_s.size = 2'b01; rdst_s = 2'b11;
      end
      default: begin dec_s.valid = 1'b0; is_trap_s = (TRAP_EN != 0); end
    endcase
    case (rdst_s)
      2'b00:   dec_s.wreg = instr[5 +: REG_ADDR_W];
      2'b01:   dec_s.wreg = instr[2 +: REG_ADDR_W];
      2'b10:   dec_s.wreg = instr[8 +: REG_ADDR_W];
      default: dec_s.wreg = '1;
    endcase
  end

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    hazard_s = 1'b0;
    if (instr_valid && ex_r.valid && ex_r.mem_read && ex_r.reg_write) begin
      hazard_s = (ex_r.wreg == instr[8 +: REG_ADDR_W]) ||
                 (uses_rt_s && (ex_r.wreg == instr[5 +: REG_ADDR_W]));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign id_live_s = (state_r == ST_RUN) && instr_valid && !flush;
  assign accept_s  = id_live_s && !hazard_s && dec_s.valid;
  assign stall     = !mem_ready || (state_r != ST_RUN) || (hazard_s && !flush);

  // Stage registers; a rejected ID slot clears only the qualifying bits in EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r        <= '0;
      mem_valid_r <= 1'b0; mem_rd_r <= 1'b0; mem_wr_r <= 1'b0;
      mem_rw_r    <= 1'b0; mem_m2r_r <= 1'b0; mem_wreg_r <= '0;
      wb_valid_r  <= 1'b0; wb_rw_r <= 1'b0; wb_m2r_r <= 1'b0; wb_wreg_r <= '0;
    end else if (mem_ready) begin
      if (accept_s) begin
        ex_r <= dec_s;
      end else begin
        ex_r.valid     <= 1'b0;
        ex_r.reg_write <= 1'b0;
        ex_r.mem_read  <= 1'b0;
        ex_r.mem_write <= 1'b0;
        ex_r.branch    <= 1'b0;
        ex_r.jump      <= 1'b0;
      end
      mem_valid_r <= ex_r.valid;     mem_rd_r  <= ex_r.mem_read;   mem_wr_r   <= ex_r.mem_write;
      mem_rw_r    <= ex_r.reg_write; mem_m2r_r <= ex_r.mem_to_reg; mem_wreg_r <= ex_r.wreg;
      wb_valid_r  <= mem_valid_r;    wb_rw_r   <= mem_rw_r;
      wb_m2r_r    <= mem_m2r_r;      wb_wreg_r <= mem_wreg_r;
    end
  end

  // HALT sequencer plus the registered illegal/dump pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      cnt_r     <= 4'd0;
      illegal_r <= 1'b0;
      dump_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      illegal_r <= mem_ready && id_live_s && !hazard_s && is_trap_s;
      dump_r    <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (mem_ready && id_live_s && !hazard_s && is_halt_s) begin
            state_r <= ST_DRAIN;
            cnt_r   <= 4'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (mem_ready) begin
            if (cnt_r == 4'd1) begin
              state_r <= ST_DONE;
              dump_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
        end
        ST_DONE: begin
          state_r  <= ST_STOP;
          halted_r <= 1'b1;
        end
        ST_STOP: halted_r <= 1'b1;
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign ex_valid     = ex_r.valid;
  assign ex_aluOp     = ex_r.alu_op;
  assign ex_aluF      = ex_r.alu_f;
  assign ex_aluSrc    = ex_r.alu_src;
  assign ex_zeroEx    = ex_r.zero_ex;
  assign ex_size      = ex_r.size;
  assign ex_branch    = ex_r.branch;
  assign ex_jump      = ex_r.jump;
  assign ex_wreg      = ex_r.wreg;
  assign mem_valid    = mem_valid_r;
  assign mem_memRead  = mem_rd_r;
  assign mem_memWrite = mem_wr_r;
  assign mem_wreg     = mem_wreg_r;
  assign wb_valid     = wb_valid_r;
  assign wb_regWrite  = wb_rw_r;
  assign wb_memToReg  = wb_m2r_r;
  assign wb_wreg      = wb_wreg_r;
  assign illegal      = illegal_r;
  assign dump         = dump_r;
  assign halted       = halted_r;

endmodule
